// File: rtl/i2c_write_seq.sv
// rtl/i2c_write_seq.sv - sequences START, three-byte register write and STOP through a byte-level I2C master
module i2c_write_seq #(
    parameter int TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       timeout_err,
    output logic       m_i2c_en,
    output logic       m_start,
    output logic       m_stop,
    output logic [7:0] m_tx_data,
    input  logic       m_ready,
    input  logic       m_tx_done
);

    // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits are enough.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_SEND    = 3'd2,
        S_STOP    = 3'd3,
        S_WAIT_LO = 3'd4,
        S_WAIT_HI = 3'd5,
        S_FIN     = 3'd6
    } state_t;

    state_t          r_state;
    state_t          r_op;       // operation whose completion WAIT_HI is waiting for
    logic [1:0]      r_idx;
    logic [6:0]      r_dev;
    logic [7:0]      r_reg;
    logic [7:0]      r_data;
    logic            r_nack;
    logic            r_to;
    logic [CW-1:0]   r_cnt;

    state_t          w_next;
    logic            w_accept;
    logic            w_strobe;
    logic            w_start;
    logic            w_stop;
    logic            w_idx_inc;
    logic            w_nack_set;
    logic            w_to_set;
    logic            w_waiting;

    // Next-state, master strobe and flag-update decisions
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_strobe   = 1'b0;
        w_start    = 1'b0;
        w_stop     = 1'b0;
        w_idx_inc  = 1'b0;
        w_nack_set = 1'b0;
        w_to_set   = 1'b0;
        w_waiting  = (r_state != S_IDLE) && (r_state != S_FIN);
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_START;
                end
            end
            S_START, S_SEND, S_STOP: begin
                if (m_ready) begin
                    w_strobe = 1'b1;
                    w_start  = (r_state == S_START);
                    w_stop   = (r_state == S_STOP);
                    w_next   = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!m_ready) w_next = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (m_ready) begin
                    case (r_op)
                        S_START: w_next = S_SEND;
                        S_SEND: begin
                            if (!m_tx_done) begin
                                w_nack_set = 1'b1;
                                w_next     = S_STOP;
                            end else if (r_idx != 2'd2) begin
                                w_idx_inc = 1'b1;
                                w_next    = S_SEND;
                            end else begin
                                w_next = S_STOP;
                            end
                        end
                        default: w_next = S_FIN;
                    endcase
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // An expired wait overrides everything: no strobe, no STOP, straight to FIN.
        if (w_waiting && (r_cnt == CNT_LAST)) begin
            w_next     = S_FIN;
            w_strobe   = 1'b0;
            w_start    = 1'b0;
            w_stop     = 1'b0;
            w_idx_inc  = 1'b0;
            w_nack_set = 1'b0;
            w_to_set   = 1'b1;
        end
    end

    // State register and per-state wait counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (!w_waiting || (w_next != r_state)) r_cnt <= '0;
            else                                   r_cnt <= r_cnt + CW'(1);
        end
    end

    // Command capture, byte index and sticky status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op   <= S_IDLE;
            r_idx  <= 2'd0;
            r_dev  <= 7'h00;
            r_reg  <= 8'h00;
            r_data <= 8'h00;
            r_nack <= 1'b0;
            r_to   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dev  <= dev_addr;
                r_reg  <= reg_addr;
                r_data <= wr_data;
                r_idx  <= 2'd0;
                r_nack <= 1'b0;
                r_to   <= 1'b0;
            end
            if (w_strobe)   r_op   <= r_state;
            if (w_idx_inc)  r_idx  <= r_idx + 2'd1;
            if (w_nack_set) r_nack <= 1'b1;
            if (w_to_set)   r_to   <= 1'b1;
        end
    end

    // Byte mux: index only moves on completion, so the byte stays stable across its transfer
    always_comb begin
        case (r_idx)
            2'd0:    m_tx_data = {r_dev, 1'b0};
            2'd1:    m_tx_data = r_reg;
            default: m_tx_data = r_data;
        endcase
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_FIN);
    assign nack        = r_nack;
    assign timeout_err = r_to;
    assign m_i2c_en    = w_strobe;
    assign m_start     = w_start;
    assign m_stop      = w_stop;

endmodule

// File: tb/tb_i2c_write_seq.sv
// tb/tb_i2c_write_seq.sv - randomized bench with behavioural I2C master and transaction-level reference
module tb_i2c_write_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] dev_addr = 7'h00;
    logic [7:0] reg_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       busy, done, nack, timeout_err;
    logic       m_i2c_en, m_start, m_stop;
    logic [7:0] m_tx_data;
    logic       m_ready = 1'b1;
    logic       m_tx_done = 1'b0;

    i2c_write_seq #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .nack(nack), .timeout_err(timeout_err),
        .m_i2c_en(m_i2c_en), .m_start(m_start), .m_stop(m_stop), .m_tx_data(m_tx_data),
        .m_ready(m_ready), .m_tx_done(m_tx_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // master-model / monitor state
    logic [9:0] log_q[$];
    int  cyc = 0;
    int  done_cnt = 0;
    int  start_cyc = 0;
    int  done_cyc = 0;
    logic last_nack = 1'b0;
    logic last_to = 1'b0;
    int  nack_byte_cfg = 3;
    bit  hang_cfg = 1'b0;
    bit  pend = 1'b0;
    bit  hanging = 1'b0;
    bit  pend_ack = 1'b1;
    logic prev_en = 1'b0;
    logic prev_done = 1'b0;
    int  busy_left = 0;
    int  send_no = 0;

    // Behavioural master: accepts a strobe, drops m_ready for a random time, reports ACK on return
    initial begin
        logic s_en, s_start, s_stop, s_ready, s_done;
        logic [7:0] s_data;
        forever begin
            @(negedge clk);
            cyc++;
            s_en = m_i2c_en; s_start = m_start; s_stop = m_stop;
            s_ready = m_ready; s_done = done; s_data = m_tx_data;
            if (!reset) begin
                m_ready = 1'b1; m_tx_done = 1'b0; pend = 1'b0; hanging = 1'b0;
                busy_left = 0; prev_en = 1'b0; prev_done = 1'b0;
            end else begin
                if (s_en) begin
                    chk("strobe_back_to_back", 32'(prev_en), 32'd0);
                    chk("strobe_without_ready", 32'(!s_ready), 32'd0);
                end
                prev_en = s_en;
                if (s_done) begin
                    chk("done_one_cycle", 32'(prev_done), 32'd0);
                    done_cnt++;
                    last_nack = nack;
                    last_to = timeout_err;
                    done_cyc = cyc;
                end
                prev_done = s_done;
                if (hanging && !hang_cfg) begin
                    hanging = 1'b0;
                    m_ready = 1'b1;
                end else if (pend) begin
                    m_ready = 1'b0; m_tx_done = 1'b0; pend = 1'b0;
                    busy_left = $urandom_range(1, 5);
                end else if (!s_ready && !hanging) begin
                    busy_left--;
                    if (busy_left <= 0) begin
                        m_ready = 1'b1;
                        m_tx_done = pend_ack;
                    end
                end
                if (s_en) begin
                    pend = 1'b1;
                    if (s_start) begin
                        log_q.push_back({2'b10, 8'h00});
                        send_no = 0; start_cyc = cyc; pend_ack = 1'b1;
                        if (hang_cfg) hanging = 1'b1;
                    end else if (s_stop) begin
                        log_q.push_back({2'b01, 8'h00});
                        pend_ack = 1'b1;
                    end else begin
                        log_q.push_back({2'b00, s_data});
                        pend_ack = (send_no != nack_byte_cfg);
                        send_no++;
                    end
                end
            end
        end
    end

    // Issue one command, optionally poke cmd_valid while busy, then compare against the transaction model
    task automatic run_cmd(input logic [6:0] d, input logic [7:0] r, input logic [7:0] w,
                           input int nb, input bit hg, input bit poke);
        logic [9:0] exp_q[$];
        logic [7:0] bytes[3];
        int n0;
        @(negedge clk);
        log_q.delete();
        nack_byte_cfg = nb;
        hang_cfg = hg;
        n0 = done_cnt;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; dev_addr = d; reg_addr = r; wr_data = w;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        if (poke) begin
            repeat (3) begin
                @(negedge clk);
                cmd_valid = 1'b1;
                dev_addr = 7'($urandom); reg_addr = 8'($urandom); wr_data = 8'($urandom);
                @(negedge clk);
                cmd_valid = 1'b0;
            end
        end
        for (int k = 0; k < 600 && done_cnt == n0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("done_count", 32'(done_cnt - n0), 32'd1);

        // reference: the write as a list of master operations
        bytes[0] = {d, 1'b0}; bytes[1] = r; bytes[2] = w;
        exp_q.push_back({2'b10, 8'h00});
        if (!hg) begin
            for (int i = 0; i < 3; i++) begin
                exp_q.push_back({2'b00, bytes[i]});
                if (i == nb) break;
            end
            exp_q.push_back({2'b01, 8'h00});
        end
        chk("op_count", 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk($sformatf("op%0d", i), 32'(log_q[i]), 32'(exp_q[i]));
        chk("nack_flag", 32'(last_nack), 32'(!hg && nb < 3));
        chk("timeout_flag", 32'(last_to), 32'(hg));
        chk("nack_held", 32'(nack), 32'(!hg && nb < 3));
        if (hg) chk("timeout_latency", 32'(done_cyc - start_cyc), 32'd18);
        hang_cfg = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {24'd0, cmd_ready, busy, done, nack, timeout_err, m_i2c_en, m_start, m_stop},
            32'h80);
        chk({tag, "_txdata"}, 32'(m_tx_data), 32'd0);
    endtask

    initial begin
        int nr;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset_state");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_cmd(7'h3C, 8'h10, 8'hA5, 3, 1'b0, 1'b0);
        run_cmd(7'h3C, 8'h10, 8'hA5, 1, 1'b0, 1'b0);
        run_cmd(7'h3C, 8'h10, 8'hA5, 0, 1'b1, 1'b0);
        run_cmd(7'h51, 8'h22, 8'h7E, 3, 1'b0, 1'b1);
        run_cmd(7'h7F, 8'hFF, 8'h00, 0, 1'b0, 1'b0);
        run_cmd(7'h01, 8'h02, 8'h03, 2, 1'b0, 1'b1);

        for (int t = 0; t < 10; t++) begin
            nr = $urandom_range(0, 5);
            run_cmd(7'($urandom), 8'($urandom), 8'($urandom), (nr > 3) ? 3 : nr,
                    1'b0, 1'($urandom_range(0, 1)));
        end

        // reset while the data byte is in flight
        @(negedge clk);
        log_q.delete();
        nack_byte_cfg = 3;
        cmd_valid = 1'b1; dev_addr = 7'h2A; reg_addr = 8'h33; wr_data = 8'hC4;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 300 && log_q.size() < 4; k++) @(negedge clk);
        chk("reached_data_byte", 32'(log_q.size()), 32'd4);
        nr = done_cnt;
        reset = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_done_on_abort", 32'(done_cnt - nr), 32'd0);
        run_cmd(7'h2A, 8'h33, 8'hC4, 3, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "bench timed out");
    end

endmodule
